// File: rtl/controlador_ciclo.sv
// Wash-cycle sequencer: fill, wash, rinse, spin, with door-open pause, cancel and fill timeout.
// Every output is registered and is computed from the next-state values, so it changes on the same edge as the phase.
module controlador_ciclo #(
   parameter int TICK_DIV     = 4,
   parameter int T_ENXAGUE    = 20,
   parameter int T_CENTRIF    = 30,
   parameter int T_ENCHER_MAX = 50
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic       i_cancelar,
   input  logic       i_porta_fechada,
   input  logic       i_nivel_cheio,
   input  logic [7:0] i_duracao_lavagem,
   output logic       o_valvula_agua,
   output logic       o_motor_lavar,
   output logic       o_motor_centrif,
   output logic [2:0] o_fase,
   output logic [7:0] o_tempo_restante,
   output logic       o_pausado,
   output logic       o_fim_ciclo
);

   // state      | meaning
   // S_IDLE     | waiting for start with the door closed
   // S_ENCHER   | filling; valve open; fill timeout running
   // S_LAVAR    | washing for the latched duration
   // S_ENXAGUAR | rinsing
   // S_CENTRIF  | spinning
   // S_FIM      | one-cycle completion pulse
   // S_ERRO     | fill timeout; waits for cancelar
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ENCHER   = 3'd1,
      S_LAVAR    = 3'd2,
      S_ENXAGUAR = 3'd3,
      S_CENTRIF  = 3'd4,
      S_FIM      = 3'd5,
      S_ERRO     = 3'd6
   } t_fase;

   localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [7:0]     C_ENCHER  = 8'(T_ENCHER_MAX);
   localparam logic [7:0]     C_ENXAGUE = 8'(T_ENXAGUE);
   localparam logic [7:0]     C_CENTRIF = 8'(T_CENTRIF);

   t_fase         r_fase, w_fase;
   logic [PW-1:0] r_presc, w_presc;
   logic [7:0]    r_tempo, w_tempo;
   logic [7:0]    r_dur, w_dur;
   logic          r_pausado, w_pausado;
   logic          r_fim, w_fim;
   logic          r_valv, w_valv;
   logic          r_mlav, w_mlav;
   logic          r_mcen, w_mcen;
   logic          w_tick;
   logic          w_ativo;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_fase    <= S_IDLE;
         r_presc   <= '0;
         r_tempo   <= '0;
         r_dur     <= '0;
         r_pausado <= 1'b0;
         r_fim     <= 1'b0;
         r_valv    <= 1'b0;
         r_mlav    <= 1'b0;
         r_mcen    <= 1'b0;
      end else begin
         r_fase    <= w_fase;
         r_presc   <= w_presc;
         r_tempo   <= w_tempo;
         r_dur     <= w_dur;
         r_pausado <= w_pausado;
         r_fim     <= w_fim;
         r_valv    <= w_valv;
         r_mlav    <= w_mlav;
         r_mcen    <= w_mcen;
      end
   end

   always_comb begin
      w_fase    = r_fase;
      w_presc   = r_presc;
      w_tempo   = r_tempo;
      w_dur     = r_dur;
      w_pausado = 1'b0;
      w_tick    = (r_presc == PRESC_MAX);
      w_ativo   = (r_fase == S_ENCHER) || (r_fase == S_LAVAR) ||
                  (r_fase == S_ENXAGUAR) || (r_fase == S_CENTRIF);

      if (i_cancelar) begin
         w_fase  = S_IDLE;
         w_presc = '0;
         w_tempo = '0;
         w_dur   = '0;
      end else if (w_ativo && !i_porta_fechada) begin
         // door open: counters and phase frozen, only the pause flag changes
         w_pausado = 1'b1;
      end else begin
         unique case (r_fase)
            S_IDLE: begin
               if (i_start && i_porta_fechada) begin
                  w_fase  = S_ENCHER;
                  w_presc = '0;
                  w_tempo = C_ENCHER;
                  w_dur   = (i_duracao_lavagem == 8'd0) ? 8'd1 : i_duracao_lavagem;
               end
            end
            S_ENCHER: begin
               // level reached wins over a simultaneous timeout tick
               if (i_nivel_cheio) begin
                  w_fase  = S_LAVAR;
                  w_presc = '0;
                  w_tempo = r_dur;
               end else if (w_tick) begin
                  w_presc = '0;
                  if (r_tempo == 8'd1) begin
                     w_fase  = S_ERRO;
                     w_tempo = '0;
                  end else begin
                     w_tempo = r_tempo - 8'd1;
                  end
               end else begin
                  w_presc = r_presc + 1'b1;
               end
            end
            S_LAVAR, S_ENXAGUAR, S_CENTRIF: begin
               if (!w_tick) begin
                  w_presc = r_presc + 1'b1;
               end else begin
                  w_presc = '0;
                  if (r_tempo == 8'd1) begin
                     if (r_fase == S_LAVAR) begin
                        w_fase  = S_ENXAGUAR;
                        w_tempo = C_ENXAGUE;
                     end else if (r_fase == S_ENXAGUAR) begin
                        w_fase  = S_CENTRIF;
                        w_tempo = C_CENTRIF;
                     end else begin
                        w_fase  = S_FIM;
                        w_tempo = '0;
                     end
                  end else begin
                     w_tempo = r_tempo - 8'd1;
                  end
               end
            end
            S_FIM: begin
               w_fase = S_IDLE;
            end
            S_ERRO: begin
               w_fase = S_ERRO;
            end
            default: begin
               w_fase  = S_IDLE;
               w_presc = '0;
               w_tempo = '0;
            end
         endcase
      end

      w_valv = (w_fase == S_ENCHER) && !w_pausado;
      w_mlav = ((w_fase == S_LAVAR) || (w_fase == S_ENXAGUAR)) && !w_pausado;
      w_mcen = (w_fase == S_CENTRIF) && !w_pausado;
      w_fim  = (w_fase == S_FIM);
   end

   assign o_fase           = r_fase;
   assign o_tempo_restante = r_tempo;
   assign o_pausado        = r_pausado;
   assign o_fim_ciclo      = r_fim;
   assign o_valvula_agua   = r_valv;
   assign o_motor_lavar    = r_mlav;
   assign o_motor_centrif  = r_mcen;

endmodule

// File: tb/tb_controlador_ciclo.sv
// Bench for controlador_ciclo: directed scenarios for the timed phases, pause, cancel and reset,
// then random panel activity, all checked every cycle against a reference model based on elapsed time.
module tb_controlador_ciclo;

   localparam int TD = 4;
   localparam int TX = 20;
   localparam int TC = 30;
   localparam int TE = 50;

   logic       clk = 1'b0;
   logic       reset, start, cancelar, porta, nivel;
   logic [7:0] dur;
   logic       o_valv, o_mlav, o_mcen, o_paus, o_fim;
   logic [2:0] o_fase;
   logic [7:0] o_tempo;

   int n_cmp = 0;
   int n_err = 0;

   // model: phase, unpaused cycles elapsed in phase, latched wash duration, pause flag
   int m_ph = 0;
   int m_el = 0;
   int m_dur = 0;
   int m_pa = 0;

   controlador_ciclo #(
      .TICK_DIV(TD), .T_ENXAGUE(TX), .T_CENTRIF(TC), .T_ENCHER_MAX(TE)
   ) dut (
      .i_clk(clk),
      .i_reset(reset),
      .i_start(start),
      .i_cancelar(cancelar),
      .i_porta_fechada(porta),
      .i_nivel_cheio(nivel),
      .i_duracao_lavagem(dur),
      .o_valvula_agua(o_valv),
      .o_motor_lavar(o_mlav),
      .o_motor_centrif(o_mcen),
      .o_fase(o_fase),
      .o_tempo_restante(o_tempo),
      .o_pausado(o_paus),
      .o_fim_ciclo(o_fim)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int phase_len(input int p);
      case (p)
         1: phase_len = TE;
         2: phase_len = m_dur;
         3: phase_len = TX;
         4: phase_len = TC;
         default: phase_len = 0;
      endcase
   endfunction

   // reference model, stepped with the values sampled at each rising edge, checked #1 later
   initial begin
      forever begin
         @(posedge clk);
         if (!reset || cancelar) begin
            m_ph = 0; m_el = 0; m_pa = 0;
         end else if (m_ph >= 1 && m_ph <= 4 && !porta) begin
            m_pa = 1;
         end else begin
            m_pa = 0;
            case (m_ph)
               0: if (start && porta) begin
                     m_dur = (dur == 8'd0) ? 1 : int'(dur);
                     m_ph = 1; m_el = 0;
                  end
               1: if (nivel) begin
                     m_ph = 2; m_el = 0;
                  end else begin
                     m_el++;
                     if (m_el == TE * TD) begin m_ph = 6; m_el = 0; end
                  end
               2, 3, 4: begin
                     m_el++;
                     if (m_el == phase_len(m_ph) * TD) begin m_ph++; m_el = 0; end
                  end
               5: m_ph = 0;
               default: ;
            endcase
         end
         #1;
         chk("fase", o_fase, m_ph);
         chk("tempo", o_tempo, (m_ph >= 1 && m_ph <= 4) ? phase_len(m_ph) - m_el / TD : 0);
         chk("valvula", o_valv, m_ph == 1 && m_pa == 0);
         chk("motor_lavar", o_mlav, (m_ph == 2 || m_ph == 3) && m_pa == 0);
         chk("motor_centrif", o_mcen, m_ph == 4 && m_pa == 0);
         chk("pausado", o_paus, m_pa);
         chk("fim_ciclo", o_fim, m_ph == 5);
      end
   end

   task automatic wait_fase(input logic [2:0] f, input int budget, output int n);
      n = 0;
      while (o_fase !== f && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_cancel();
      cancelar = 1'b1;
      @(negedge clk);
      chk("cancel_fase", o_fase, 0);
      cancelar = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n;
      int nivel_en;
      reset = 1'b0; start = 1'b0; cancelar = 1'b0; porta = 1'b1; nivel = 1'b0; dur = 8'd60;
      repeat (3) @(negedge clk);
      chk("reset_fase", o_fase, 0);
      chk("reset_tempo", o_tempo, 0);
      reset = 1'b1;
      @(negedge clk);

      // full cycle, wash 60, level reached after 10 cycles
      dur = 8'd60; start = 1'b1;
      wait_fase(3'd1, 10, n);
      start = 1'b0;
      repeat (10) @(negedge clk);
      nivel = 1'b1;
      wait_fase(3'd2, 20, n);
      wait_fase(3'd3, 300, n); chk("lavar_len", n, 240);
      wait_fase(3'd4, 200, n); chk("enxaguar_len", n, 80);
      wait_fase(3'd5, 200, n); chk("centrif_len", n, 120);
      chk("fim_pulse", o_fim, 1);
      @(negedge clk);
      chk("fim_one_cycle", o_fim, 0);
      chk("fim_to_idle", o_fase, 0);
      nivel = 1'b0;

      // duration latched at start; later changes ignored
      dur = 8'd100; nivel = 1'b1; start = 1'b1;
      wait_fase(3'd2, 10, n);
      start = 1'b0;
      repeat (100) @(negedge clk);
      dur = 8'd60;
      wait_fase(3'd3, 500, n); chk("lavar_latched", n + 100, 400);
      do_cancel();

      // fill timeout
      nivel = 1'b0; start = 1'b1;
      wait_fase(3'd1, 10, n);
      start = 1'b0;
      wait_fase(3'd6, 300, n); chk("encher_timeout", n, 200);
      chk("erro_valvula", o_valv, 0);
      repeat (5) @(negedge clk);
      chk("erro_held", o_fase, 6);
      do_cancel();

      // door opens at 37 remaining for 50 cycles
      dur = 8'd60; nivel = 1'b1; start = 1'b1;
      wait_fase(3'd2, 10, n);
      start = 1'b0;
      n = 0;
      while (o_tempo !== 8'd37 && n < 300) begin @(negedge clk); n++; end
      chk("tempo_37", o_tempo, 37);
      porta = 1'b0;
      @(negedge clk);
      chk("pausa_flag", o_paus, 1);
      chk("pausa_motor", o_mlav, 0);
      chk("pausa_tempo", o_tempo, 37);
      repeat (49) @(negedge clk);
      chk("pausa_tempo_end", o_tempo, 37);
      porta = 1'b1;
      @(negedge clk);
      chk("resume_flag", o_paus, 0);
      chk("resume_motor", o_mlav, 1);
      chk("resume_tempo", o_tempo, 37);
      wait_fase(3'd3, 400, n); chk("pausa_total", n + 51, 198);
      do_cancel();

      // cancel during spin
      dur = 8'd2; nivel = 1'b1; start = 1'b1;
      wait_fase(3'd4, 500, n);
      start = 1'b0;
      repeat (3) @(negedge clk);
      cancelar = 1'b1;
      @(negedge clk);
      chk("cancel_centrif_fase", o_fase, 0);
      chk("cancel_centrif_motor", o_mcen, 0);
      chk("cancel_centrif_fim", o_fim, 0);
      cancelar = 1'b0;
      repeat (5) @(negedge clk);

      // reset in rinse, start with door open, zero duration
      start = 1'b1;
      wait_fase(3'd3, 500, n);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_fase", o_fase, 0);
      chk("rst_mid_motor", o_mlav, 0);
      chk("rst_mid_tempo", o_tempo, 0);
      reset = 1'b1;
      porta = 1'b0; start = 1'b1;
      repeat (5) @(negedge clk);
      chk("start_door_open", o_fase, 0);
      start = 1'b0; porta = 1'b1;
      @(negedge clk);
      dur = 8'd0; start = 1'b1;
      wait_fase(3'd2, 10, n);
      start = 1'b0;
      wait_fase(3'd3, 50, n); chk("dur0_len", n, TD);
      do_cancel();

      // random panel activity
      nivel_en = 1;
      for (int i = 0; i < 15000; i++) begin
         @(negedge clk);
         start    = ($urandom % 8) == 0;
         cancelar = ($urandom % 250) == 0;
         reset    = ($urandom % 900) != 0;
         if (($urandom % 40) == 0) porta = ~porta;
         if (($urandom % 400) == 0) nivel_en = 1 - nivel_en;
         nivel = (nivel_en != 0) && (($urandom % 12) == 0);
         dur   = 8'($urandom % 6);
      end
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
